// File: rtl/switch_allocator_if.sv
// Allocator-side bundle: head-flit requests and credit returns in, crossbar selects and
// dequeue grants out.
interface switch_allocator_if #(
    parameter int PORT_NUM = 5
);
    logic [PORT_NUM-1:0][PORT_NUM-1:0] req;
    logic [PORT_NUM-1:0]               credit_in;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] port_sel;
    logic [PORT_NUM-1:0]               grant_out;
    logic                              credit_err;

    modport master (
        output req,
        output credit_in,
        input  port_sel,
        input  grant_out,
        input  credit_err
    );

    modport slave (
        input  req,
        input  credit_in,
        output port_sel,
        output grant_out,
        output credit_err
    );
endinterface

// File: rtl/switch_allocator.sv
// Credit-aware per-output round-robin switch allocator feeding a PORT_NUM x PORT_NUM crossbar.
// Define SA_CREDIT_CHECK_EN to build the sticky credit/request protocol checker.
module switch_allocator #(
    parameter int PORT_NUM     = 5,
    parameter int BUFFER_DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    switch_allocator_if.slave bus
);
    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam int RW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    logic [PORT_NUM-1:0][CW-1:0]       credit_q, credit_d;
    logic [PORT_NUM-1:0][RW-1:0]       rr_q, rr_d;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] sel_q, sel_d;
    logic [PORT_NUM-1:0]               grant_q, grant_d;
    logic [PORT_NUM-1:0]               out_gnt;

    always_comb begin : arbitrate
        int   idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        sel_d   = '0;
        rr_d    = rr_q;
        out_gnt = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            found = 1'b0;
            for (int k = 0; k < PORT_NUM; k++) begin
                idx = int'(rr_q[o]) + k;
                if (idx >= PORT_NUM) idx = idx - PORT_NUM;
                if (!found && bus.req[idx][o] && (credit_q[o] != '0)) begin
                    found         = 1'b1;
                    sel_d[idx][o] = 1'b1;
                    rr_d[o]       = RW'((idx + 1) % PORT_NUM);
                end
            end
            out_gnt[o] = found;
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            grant_d[i] = |sel_d[i];
        end
    end

    // A returned credit at full count saturates rather than wrapping.
    always_comb begin : credit_next
        int c;
        c        = 0;
        credit_d = credit_q;
        for (int o = 0; o < PORT_NUM; o++) begin
            c = int'(credit_q[o]) + int'(bus.credit_in[o]) - int'(out_gnt[o]);
            if (c > BUFFER_DEPTH) c = BUFFER_DEPTH;
            credit_d[o] = CW'(c);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                credit_q[o] <= CW'(BUFFER_DEPTH);
            end
            rr_q    <= '0;
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            credit_q <= credit_d;
            rr_q     <= rr_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
        end
    end

    assign bus.port_sel  = sel_q;
    assign bus.grant_out = grant_q;

`ifdef SA_CREDIT_CHECK_EN
    logic err_q, err_d, err_cond;

    always_comb begin : credit_check
        err_cond = 1'b0;
        for (int o = 0; o < PORT_NUM; o++) begin
            if (bus.credit_in[o] && (credit_q[o] == CW'(BUFFER_DEPTH)) && !out_gnt[o]) begin
                err_cond = 1'b1;
            end
        end
        // Clearing the lowest set bit leaves something only if the row is not one-hot.
        for (int i = 0; i < PORT_NUM; i++) begin
            if ((bus.req[i] & (bus.req[i] - PORT_NUM'(1))) != '0) err_cond = 1'b1;
        end
        err_d = err_q | err_cond;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign bus.credit_err = err_q;

    credit_protocol_a: assert property (@(posedge clk) disable iff (reset) !err_cond);
`else
    assign bus.credit_err = 1'b0;
`endif
endmodule
